ps_sobel_filter: RTL
====================

Name: ps_sobel_filter

Overview:
Downstream compute stage of the 3x3 kernel window path. Consumes three 24-bit row slices (top/middle/bottom, 3 pixels each) plus a valid strobe from the kernel control stage and computes the Sobel gradient magnitude |Gx|+|Gy| per window. The result is an 8-bit pixel, either saturated or thresholded to binary. A fixed-latency pipeline with no backpressure also tracks frame position and emits start-of-frame and end-of-line markers for the output writer.

Parameters:
IMG_W, 640, pixels per line (column counter wrap)
IMG_H, 480, lines per frame (row counter wrap)
LATENCY, 4, i_valid to o_valid pipeline depth in cycles (fixed, informational; not configurable)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, synchronous, active-low
i_r0_data  in  24  top row: [23:16] left pixel, [15:8] centre, [7:0] right
i_r1_data  in  24  middle row, same packing
i_r2_data  in  24  bottom row, same packing
i_valid  in  1  window valid; one window per cycle when high
i_thresh_en  in  1  1 = binary threshold output, 0 = saturated magnitude
i_thresh  in  11  threshold on the 11-bit magnitude
o_data  out  8  output pixel
o_valid  out  1  o_data valid
o_sof  out  1  high with o_valid on pixel (row 0, col 0)
o_eol  out  1  high with o_valid on col IMG_W-1 of every row

Behaviour:
- Reset: i_rstn is synchronous, active-low. All pipeline valid bits, o_data, o_valid, o_sof and o_eol reset to 0. Column/row counters reset to 0. Latched threshold settings reset to en=0, thresh=0.
- Notation pRC: R = row 0..2 (top..bottom), C = col 0..2 (left..right).
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
- Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02).
- Width rules:
  - Each partial sum is unsigned, max 1020, 10 bits.
  - Gx and Gy are signed 11-bit, range -1020..+1020.
  - mag = |Gx| + |Gy| is unsigned 11-bit, max 2040. No overflow is possible.
- Output mapping:
  - thresh_en = 1: o_data = (mag >= thresh) ? 255 : 0.
  - thresh_en = 0: o_data = (mag > 255) ? 255 : mag[7:0].
- Pipeline, one register stage per step:
  - S1: register the inputs.
  - S2: four partial sums.
  - S3: Gx and Gy, then absolute values.
  - S4: magnitude and output mapping, registered into o_data.
- Latency: o_valid asserts exactly 4 cycles after the i_valid it belongs to.
- Throughput: 1 window per cycle. Bubbles (i_valid low) propagate unchanged, so o_valid exactly mirrors i_valid delayed 4 cycles.
- o_data holds its last value while o_valid is low.
- No backpressure: the consumer must always accept output.
- Position tracking on input:
  - Counters advance only on i_valid.
  - col wraps IMG_W-1 -> 0; row increments on that wrap and wraps IMG_H-1 -> 0.
  - sof = (row == 0 && col == 0); eol = (col == IMG_W-1). Both flags travel down the pipeline with their window.
- Threshold latch: i_thresh_en and i_thresh are sampled only on an i_valid with row == 0 and col == 0. That value applies to the whole frame, and mid-frame changes are ignored. The first frame after reset uses the sampled value, since sampling happens at the S1 entry of pixel (0,0).
- Simultaneous events: eol and frame wrap on the same valid (col = IMG_W-1, row = IMG_H-1). Output that pixel with eol=1; the next valid is sof.
- Reset mid-frame: the pipeline is flushed, and in-flight windows are discarded with no o_valid. The next i_valid is treated as (0,0) and raises o_sof 4 cycles later.
- No state machine beyond the counters. The block is a pure streaming datapath.

Decomposition:
- Shared package ps_pkg: PIXEL_W = 8, ROW_W = 24, MAG_W = 11, IMG_W/IMG_H defaults, and the row-slice packing constants (left/centre/right bit offsets). The kernel control stage and this block both use these.
- One natural sub-module: ps_pos_tracker, holding the col/row counters plus the sof/eol flag generation. It is reusable by other window-processing stages.

Test Plan:
- Flat window, all pixels 100, 10 consecutive valids -> o_data = 0 for all, o_valid exactly 4 cycles after each i_valid.
- Vertical edge, rows = {0,0,255} each, thresh_en = 0 -> Gx = 1020, Gy = 0, mag = 1020, o_data = 255 (saturated).
- Weak gradient, rows = {10,10,20} each -> mag = 40, o_data = 40. Same window with thresh_en = 1, thresh = 41 latched at sof -> o_data = 0; with thresh = 40 -> 255.
- Random valid bubbles (~30% low) over 100 windows -> o_valid pattern equals i_valid delayed 4 cycles, and data matches the reference model in order.
- Full frame, IMG_W = 8, IMG_H = 4 (overridden) -> o_eol on output pixels 7, 15, 23, 31; o_sof on output 0 and 32. Changing i_thresh mid-frame has no effect until the next sof.
- Reset asserted 2 cycles after 3 valids of a frame -> no o_valid from those windows; the next i_valid yields o_sof = 1 4 cycles later.

Source files
------------

// File: rtl/ps_pkg.sv
// ----------------------------------------------------------------------------
// ps_pkg
// Shared definitions for the 3x3 kernel window path: pixel/row/magnitude
// widths, default image geometry, row-slice packing offsets and small
// helpers used by the kernel control stage and the Sobel compute stage.
// ----------------------------------------------------------------------------
package ps_pkg;

    localparam int unsigned PIXEL_W   = 8;
    localparam int unsigned ROW_W     = 24;
    localparam int unsigned MAG_W     = 11;
    localparam int unsigned PSUM_W    = 10;   // a + 2b + c of 8-bit pixels
    localparam int unsigned IMG_W_DEF = 640;
    localparam int unsigned IMG_H_DEF = 480;

    // Row slice packing: left pixel in the MSBs, right pixel in the LSBs.
    localparam int unsigned LEFT_LSB   = 16;
    localparam int unsigned CENTRE_LSB = 8;
    localparam int unsigned RIGHT_LSB  = 0;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [PSUM_W-1:0]  psum_t;
    typedef logic [MAG_W-1:0]   mag_t;

    localparam pixel_t PIX_MAX = '1;

    typedef struct packed {
        pixel_t left;
        pixel_t centre;
        pixel_t right;
    } row_slice_t;

    // Sideband that travels down the pipeline alongside each window.
    typedef struct packed {
        logic sof;
        logic eol;
        logic thr_en;
        mag_t thr;
    } tag_t;

    function automatic row_slice_t unpack_row(input row_t r);
        row_slice_t s;
        s.left   = r[LEFT_LSB   +: PIXEL_W];
        s.centre = r[CENTRE_LSB +: PIXEL_W];
        s.right  = r[RIGHT_LSB  +: PIXEL_W];
        return s;
    endfunction

    // Weighted 1-2-1 sum; max 4*255 = 1020 fits PSUM_W.
    function automatic psum_t wsum(input pixel_t a, input pixel_t b, input pixel_t c);
        return psum_t'(a) + psum_t'({b, 1'b0}) + psum_t'(c);
    endfunction

    // Counter width for a modulus n (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps_pos_tracker.sv
// ----------------------------------------------------------------------------
// ps_pos_tracker
// Column/row position counters for a raster stream of windows. Counters
// advance only on i_valid; col wraps IMG_W-1 -> 0 and row advances on that
// wrap, wrapping IMG_H-1 -> 0. Flags describe the window currently presented.
//
// Ports:
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_valid       : a window is consumed this cycle
//   o_sof         : current position is (row 0, col 0)
//   o_eol         : current position is col IMG_W-1
// ----------------------------------------------------------------------------
module ps_pos_tracker
    import ps_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_valid,
    output logic o_sof,
    output logic o_eol
);

    localparam int unsigned CW = cnt_w(IMG_W);
    localparam int unsigned LW = cnt_w(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [LW-1:0] ROW_LAST = LW'(IMG_H - 1);

    logic [CW-1:0] col_q;
    logic [LW-1:0] row_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (i_valid) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + LW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_comb begin
        o_sof = (col_q == '0) && (row_q == '0);
        o_eol = (col_q == COL_LAST);
    end

endmodule

// File: rtl/ps_sobel_filter.sv
// ----------------------------------------------------------------------------
// ps_sobel_filter
// Sobel gradient magnitude |Gx|+|Gy| on a stream of 3x3 windows, 1 window per
// cycle, fixed 4-cycle latency, no backpressure. Output is either the
// magnitude saturated to 8 bits or a binary threshold result. Frame position
// markers (sof/eol) travel with each window.
//
// Ports:
//   i_clk, i_rstn        : clock, synchronous active-low reset
//   i_r0/r1/r2_data[23:0]: top/middle/bottom row, {left, centre, right}
//   i_valid              : window valid
//   i_thresh_en          : 1 = binary threshold output, 0 = saturated magnitude
//   i_thresh[10:0]       : threshold on the 11-bit magnitude
//   o_data[7:0]          : output pixel (holds while o_valid is low)
//   o_valid              : o_data valid, i_valid delayed by 4 cycles
//   o_sof                : with o_valid on pixel (row 0, col 0)
//   o_eol                : with o_valid on col IMG_W-1
// ----------------------------------------------------------------------------
module ps_sobel_filter
    import ps_pkg::*;
#(
    parameter int unsigned IMG_W   = IMG_W_DEF,
    parameter int unsigned IMG_H   = IMG_H_DEF,
    parameter int unsigned LATENCY = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [ROW_W-1:0]    i_r0_data,
    input  logic [ROW_W-1:0]    i_r1_data,
    input  logic [ROW_W-1:0]    i_r2_data,
    input  logic                i_valid,
    input  logic                i_thresh_en,
    input  logic [MAG_W-1:0]    i_thresh,
    output logic [PIXEL_W-1:0]  o_data,
    output logic                o_valid,
    output logic                o_sof,
    output logic                o_eol
);

    // Sideband stages S1..S3; the S4 stage is the output register itself.
    localparam int unsigned SB = LATENCY - 1;

    logic pos_sof;
    logic pos_eol;

    ps_pos_tracker #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_sof   (pos_sof),
        .o_eol   (pos_eol)
    );

    // ------------------------------------------------------------------
    // Threshold latch and sideband pipeline
    // ------------------------------------------------------------------
    logic              thr_en_q;
    mag_t              thr_q;
    tag_t              tag_in;
    tag_t              tag_out;
    logic [SB-1:0]     vld_q;
    tag_t [SB-1:0]     tag_q;

    // The threshold rides with each window so the last pixels of a frame
    // still see that frame's setting after the next sof re-latches it.
    // Pixel (0,0) takes the live inputs since the latch updates alongside it.
    always_comb begin
        tag_in     = '0;
        tag_in.sof = pos_sof;
        tag_in.eol = pos_eol;
        if (i_valid && pos_sof) begin
            tag_in.thr_en = i_thresh_en;
            tag_in.thr    = i_thresh;
        end else begin
            tag_in.thr_en = thr_en_q;
            tag_in.thr    = thr_q;
        end
    end

    assign tag_out = tag_q[SB-1];

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed; qualified by the valid chain)
    // ------------------------------------------------------------------
    row_t       r0_q, r1_q, r2_q;
    row_slice_t t_s, m_s, b_s;
    psum_t      gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
    logic signed [MAG_W-1:0] gx_s, gy_s;
    mag_t       abs_gx, abs_gy;
    mag_t       abs_gx_q, abs_gy_q;
    mag_t       mag;
    pixel_t     pix_out;

    always_comb begin
        t_s = unpack_row(r0_q);
        m_s = unpack_row(r1_q);
        b_s = unpack_row(r2_q);
    end

    always_comb begin
        gx_s   = $signed(MAG_W'(gx_pos_q)) - $signed(MAG_W'(gx_neg_q));
        gy_s   = $signed(MAG_W'(gy_pos_q)) - $signed(MAG_W'(gy_neg_q));
        abs_gx = gx_s[MAG_W-1] ? mag_t'(-gx_s) : mag_t'(gx_s);
        abs_gy = gy_s[MAG_W-1] ? mag_t'(-gy_s) : mag_t'(gy_s);
    end

    always_comb begin
        mag = abs_gx_q + abs_gy_q;
        if (tag_out.thr_en) begin
            pix_out = (mag >= tag_out.thr) ? PIX_MAX : '0;
        end else begin
            pix_out = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIXEL_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        // S1: capture rows
        r0_q <= i_r0_data;
        r1_q <= i_r1_data;
        r2_q <= i_r2_data;
        // S2: partial sums (right col, left col, bottom row, top row)
        gx_pos_q <= wsum(t_s.right,  m_s.right,  b_s.right);
        gx_neg_q <= wsum(t_s.left,   m_s.left,   b_s.left);
        gy_pos_q <= wsum(b_s.left,   b_s.centre, b_s.right);
        gy_neg_q <= wsum(t_s.left,   t_s.centre, t_s.right);
        // S3: absolute gradients
        abs_gx_q <= abs_gx;
        abs_gy_q <= abs_gy;
    end

    // ------------------------------------------------------------------
    // Control registers and S4 output stage
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            thr_en_q <= 1'b0;
            thr_q    <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
            o_data   <= '0;
        end else begin
            if (i_valid && pos_sof) begin
                thr_en_q <= i_thresh_en;
                thr_q    <= i_thresh;
            end
            vld_q   <= {vld_q[SB-2:0], i_valid};
            tag_q   <= {tag_q[SB-2:0], tag_in};
            o_valid <= vld_q[SB-1];
            o_sof   <= vld_q[SB-1] & tag_out.sof;
            o_eol   <= vld_q[SB-1] & tag_out.eol;
            if (vld_q[SB-1]) begin
                o_data <= pix_out;
            end
        end
    end

endmodule
